// File: rtl/chip_6502_bus_pkg.sv
`default_nettype none
// ============================================================================
// chip_6502_bus_pkg : shared types and helpers for the 6502 bus sequencer
// Revision 1.0
// ============================================================================
package chip_6502_bus_pkg;

    typedef enum logic [1:0] {
        PHI1  = 2'd0,
        ADDR  = 2'd1,
        PHI2  = 2'd2,
        WDATA = 2'd3
    } phase_t;

    localparam int MIN_SETTLE = 2;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip_6502_res_stretch.sv
`default_nettype none
// ============================================================================
// chip_6502_res_stretch : holds cpu_res low for RESET_CYCLES phi rising edges
// Revision 1.0
// ============================================================================
module chip_6502_res_stretch
    import chip_6502_bus_pkg::*;
#(
    parameter int RESET_CYCLES = 8
) (
    input  logic clk,
    input  logic res,
    input  logic phi,
    output logic cpu_res
);

    localparam int c_cw = cnt_width(RESET_CYCLES + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(RESET_CYCLES - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic            r_phi_d;
    logic [c_cw-1:0] r_cnt;
    logic            r_cpu_res;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_phi_d   <= 1'b0;
            r_cnt     <= '0;
            r_cpu_res <= 1'b0;
        end else begin
            r_phi_d <= phi;
            // Counting stops once released so cpu_res can never drop again.
            if (phi && !r_phi_d && !r_cpu_res) begin
                if (r_cnt == c_last) begin
                    r_cpu_res <= 1'b1;
                end
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign cpu_res = r_cpu_res;

endmodule
`default_nettype wire

// File: rtl/chip_6502_bus.sv
`default_nettype none
// ============================================================================
// chip_6502_bus : phi generator and handshaked memory bridge for chip_6502
// Revision 1.0
// ============================================================================
module chip_6502_bus
    import chip_6502_bus_pkg::*;
#(
    parameter int SETTLE       = 8,
    parameter int RESET_CYCLES = 8
) (
    input  logic        clk,
    input  logic        res,
    output logic        phi,
    output logic        cpu_res,
    input  logic [15:0] ab,
    input  logic        rw,
    input  logic [7:0]  dbo,
    input  logic        sync,
    output logic [7:0]  dbi,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_fetch,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    localparam int c_cw = cnt_width(SETTLE);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(SETTLE - 1);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

    generate
        if (SETTLE < MIN_SETTLE || RESET_CYCLES < 1) begin : g_param_check
            $error("chip_6502_bus: SETTLE must be >= %0d and RESET_CYCLES >= 1", MIN_SETTLE);
        end
    endgenerate

    phase_t          r_state, w_state;
    logic [c_cw-1:0] r_cnt,   w_cnt;
    logic            r_rw_q,  w_rw_q;
    logic            r_phi,   w_phi;
    logic            r_req,   w_req;
    logic            r_we,    w_we;
    logic [15:0]     r_addr,  w_addr;
    logic [7:0]      r_wdata, w_wdata;
    logic            r_fetch, w_fetch;
    logic [7:0]      r_dbi,   w_dbi;
    logic            w_cnt_done;

    assign w_cnt_done = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= PHI1;
            r_cnt   <= '0;
            r_rw_q  <= 1'b1;
            r_phi   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 8'h00;
            r_fetch <= 1'b0;
            r_dbi   <= 8'h00;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_rw_q  <= w_rw_q;
            r_phi   <= w_phi;
            r_req   <= w_req;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_fetch <= w_fetch;
            r_dbi   <= w_dbi;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_rw_q  = r_rw_q;
        w_req   = r_req;
        w_we    = r_we;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_fetch = r_fetch;
        w_dbi   = r_dbi;
        case (r_state)
            PHI1: begin
                if (w_cnt_done) begin
                    w_cnt   = '0;
                    w_state = ADDR;
                    w_addr  = ab;
                    w_rw_q  = rw;
                    w_fetch = sync;
                    if (rw) begin
                        w_req = 1'b1;
                        w_we  = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                end
            end
            ADDR: begin
                if (!r_rw_q) begin
                    w_state = PHI2;
                end else if (r_req && mem_ack) begin
                    w_dbi   = mem_rdata;
                    w_req   = 1'b0;
                    w_state = PHI2;
                end
            end
            PHI2: begin
                if (w_cnt_done) begin
                    w_cnt   = '0;
                    w_state = WDATA;
                    if (!r_rw_q) begin
                        w_wdata = dbo;
                        w_req   = 1'b1;
                        w_we    = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + c_cnt_one;
                end
            end
            WDATA: begin
                if (r_rw_q) begin
                    w_state = PHI1;
                end else if (r_req && mem_ack) begin
                    w_req   = 1'b0;
                    w_we    = 1'b0;
                    w_state = PHI1;
                end
            end
            default: w_state = PHI1;
        endcase
        // phi is registered from the next phase so it never glitches.
        w_phi = (w_state == PHI2) || (w_state == WDATA);
    end

    chip_6502_res_stretch #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_res_stretch (
        .clk     (clk),
        .res     (res),
        .phi     (r_phi),
        .cpu_res (cpu_res)
    );

    assign phi       = r_phi;
    assign dbi       = r_dbi;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_fetch = r_fetch;

endmodule
`default_nettype wire

// File: doc/chip_6502_bus.md
# chip_6502_bus

Bus sequencer sitting directly around `chip_6502`. It generates the 6502 clock `phi` from the FPGA clock, holds the CPU in reset after system reset, and converts the CPU's `ab`/`rw`/`dbo` outputs into handshaked memory requests. Read data is returned to the CPU on `dbi`. `phi` is stretched while memory is busy, so the gate-level core always sees settled inputs.

## Interface
Parameters:
- `SETTLE`, 8: clk cycles per phi half-phase (minimum 2).
- `RESET_CYCLES`, 8: full phi cycles `cpu_res` is held low after `res` deasserts (minimum 1).

Ports:
- `clk` in 1: FPGA clock; the one clock, all state on its rising edge.
- `res` in 1: asynchronous, active-low reset.
- `phi` out 1: 6502 clock to `chip_6502.phi`.
- `cpu_res` out 1: active-low CPU reset to `chip_6502.res`.
- `ab` in 16: CPU address.
- `rw` in 1: CPU read/write, 1 = read.
- `dbo` in 8: CPU write data.
- `sync` in 1: CPU opcode-fetch flag.
- `dbi` out 8: read data to CPU, registered.
- `mem_req` out 1: request valid.
- `mem_we` out 1: 1 = write request.
- `mem_addr` out 16: request address.
- `mem_wdata` out 8: write data.
- `mem_fetch` out 1: request is an opcode fetch (`sync` captured).
- `mem_ack` in 1: request complete; read data valid on the same cycle.
- `mem_rdata` in 8: read data.

## Operation
- States:
  - PHI1: `phi`=0, counts SETTLE clks.
  - ADDR: `phi`=0, read access.
  - PHI2: `phi`=1, counts SETTLE clks.
  - WDATA: `phi`=1, write access.
  - The cycle is PHI1→ADDR→PHI2→WDATA→PHI1.
- Leaving PHI1 on the edge it ends:
  - Capture `ab`→`mem_addr`, `rw`→internal `rw_q`, `sync`→`mem_fetch`.
  - If `rw`=1, also set `mem_req`=1 and `mem_we`=0.
- ADDR, read (`rw_q`=1): wait for an edge with `mem_req`&`mem_ack`. On that edge: `dbi`←`mem_rdata`, `mem_req`←0, go to PHI2.
- ADDR, write (`rw_q`=0): lasts exactly 1 clk with no request.
- Leaving PHI2 on the edge it ends:
  - If `rw_q`=0, capture `dbo`→`mem_wdata` and set `mem_req`=1, `mem_we`=1.
  - Otherwise WDATA lasts exactly 1 clk with no request.
- WDATA, write: on the edge with `mem_ack`, set `mem_req`←0 and `mem_we`←0, then go to PHI1.
- `mem_addr`, `mem_wdata`, `mem_we` and `mem_fetch` are stable for the whole time `mem_req`=1. `dbi` holds its value until the next read ack.
- `mem_ack` is ignored whenever `mem_req`=0.
- Reset stretcher:
  - `cpu_res` stays 0 until RESET_CYCLES rising edges of `phi` have occurred after `res` deasserts, then goes 1 and stays there.
  - Memory accesses run normally while `cpu_res`=0.
- `res` asserted (low) at any time asynchronously forces all registers to reset values. An outstanding request is abandoned; memory must tolerate `mem_req` dropping without an ack.

## Timing
- Reset values:
  - `phi`=0, `cpu_res`=0, `dbi`=0x00.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0x0000, `mem_wdata`=0x00, `mem_fetch`=0.
  - State PHI1, counter 0, reset-stretch counter 0.
- First PHI1 begins on the first clk edge after `res` deasserts.
- Phi period with zero-wait memory (ack in the first cycle `mem_req` is high) is 2·SETTLE+2 clks:
  - `phi` low SETTLE+1 clks.
  - `phi` high SETTLE+1 clks.
- Each wait cycle with `mem_req`=1 and `mem_ack`=0 stretches the current phase by 1 clk. Stretch is unbounded.
- `dbi` updates at least SETTLE clks before `phi` falls.
- `ab`/`rw`/`sync` are sampled at the end of PHI1; `dbo` is sampled at the end of PHI2. The CPU must not change them within a phase.
- Read request latency: `mem_req` rises SETTLE clks after `phi` falls. Write request: SETTLE clks after `phi` rises.

## Structure
- Package `chip_6502_bus_pkg`:
  - State enum (PHI1, ADDR, PHI2, WDATA).
  - `MIN_SETTLE`=2.
  - Counter-width function.
- Elaboration check: SETTLE ≥ MIN_SETTLE and RESET_CYCLES ≥ 1.
- One sub-module, `chip_6502_res_stretch`: counts `phi` rising edges and drives `cpu_res`.
- The phase FSM and request registers live in the top.

## Test plan
- Reset, SETTLE=4, RESET_CYCLES=3, always-ack memory, `rw`=1 → `phi` period exactly 10 clks (5 low, 5 high). `cpu_res` rises after the 3rd `phi` rising edge.
- `ab`=0xFFFC, `rw`=1, `sync`=1, memory returns 0xA9 after 3 wait cycles → `mem_addr`=0xFFFC and `mem_fetch`=1 held through the waits. `phi` low phase is 8 clks. `dbi`=0xA9 before `phi` rises.
- Write `ab`=0x0200, `dbo`=0x5A, `rw`=0 → no request during ADDR. In WDATA: `mem_we`=1, `mem_addr`=0x0200, `mem_wdata`=0x5A. `phi` stays high until ack.
- Glitch `mem_ack`=1 with `mem_req`=0 during PHI1 and PHI2 → no state change, `dbi` unchanged.
- Assert `res` low during an unacked read → all outputs at reset values immediately, including `mem_req`=0. Sequencing restarts from PHI1 with `cpu_res`=0.
- Back-to-back read 0x1000 (0x11), write 0x1001 (0x22), read 0x1000 → reference memory model matches. `dbi`=0x11 on both reads.
